// File: rtl/type_buffer.sv
// rtl/type_buffer.sv - typed-text accumulator and round timer feeding the VGA text renderer; optional macro BACKSPACE_EN
module type_buffer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int SLOTS  = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           tgt_len,
  input  logic [5*SLOTS-1:0]   target,
  input  logic                 key_valid,
  input  logic [4:0]           key_code,
  input  logic                 key_bksp,
  output logic [5*SLOTS-1:0]   type_data,
  output logic [4:0]           tot,
  output logic [SLOTS-1:0]     correct,
  output logic [14:0]          times,
  output logic [9:0]           err_cnt,
  output logic                 done
);

  localparam logic [4:0]  MAX_LEN    = 5'(SLOTS);
  localparam logic [31:0] PRESC_LAST = 32'(CLK_HZ / 10 - 1);
  localparam logic [14:0] TIMES_MAX  = 15'h7FFF;
  localparam logic [9:0]  ERR_MAX    = 10'h3FF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READY  = 2'd1,
    S_TYPING = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  len_r;
  logic [31:0] presc;

  logic        code_ok;
  logic        accept;
  logic        bksp_hit;
  logic        bksp_block;
  logic        key_match;
  logic        run;
  logic [4:0]  wr_idx;
  logic [6:0]  wr_base;
  logic [4:0]  tot_inc;
  logic [4:0]  len_clamped;

  // key_bksp has no reader when backspace support is compiled out
  logic        unused_bksp;
  assign unused_bksp = key_bksp;

  // decode this cycle's action: start, accepted key, or backspace
  always_comb begin
    bksp_block = 1'b0;
    bksp_hit   = 1'b0;
`ifdef BACKSPACE_EN
    bksp_block = key_bksp;
    bksp_hit   = key_bksp && (state == S_TYPING) && (tot != 5'd0);
`endif
    code_ok     = (key_code >= 5'd1) && (key_code <= 5'd27);
    accept      = !start && !bksp_block && key_valid && code_ok &&
                  ((state == S_READY) || (state == S_TYPING)) && (tot < len_r);
    tot_inc     = tot + 5'd1;
    wr_idx      = bksp_hit ? (tot - 5'd1) : tot;
    wr_base     = 7'({2'b00, wr_idx} * 7'd5);
    key_match   = (key_code == target[wr_base +: 5]);
    len_clamped = ((tgt_len == 5'd0) || (tgt_len > MAX_LEN)) ? MAX_LEN : tgt_len;
  end

  // next-state logic; the timer runs on every edge that lands in TYPING from READY/TYPING
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_READY;
    end else if (accept) begin
      state_next = (tot_inc == len_r) ? S_DONE : S_TYPING;
    end
    run = ((state == S_READY) || (state == S_TYPING)) && (state_next == S_TYPING);
  end

  // state register and registered done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == S_DONE);
    end
  end

  // slot buffer, correctness mask, counters and round length
  always_ff @(posedge clk) begin
    if (rst) begin
      type_data <= '0;
      correct   <= '0;
      tot       <= 5'd0;
      err_cnt   <= 10'd0;
      len_r     <= MAX_LEN;
    end else if (start) begin
      type_data <= '0;
      correct   <= '0;
      tot       <= 5'd0;
      err_cnt   <= 10'd0;
      len_r     <= len_clamped;
    end else if (accept) begin
      type_data[wr_base +: 5] <= key_code;
      correct[wr_idx]         <= key_match;
      tot                     <= tot_inc;
      if (!key_match && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 10'd1;
      end
    end else if (bksp_hit) begin
      type_data[wr_base +: 5] <= 5'd0;
      correct[wr_idx]         <= 1'b0;
      tot                     <= wr_idx;
    end
  end

  // tenth-of-a-second prescaler and saturating elapsed time
  always_ff @(posedge clk) begin
    if (rst || start) begin
      presc <= 32'd0;
      times <= 15'd0;
    end else if (run) begin
      if (presc == PRESC_LAST) begin
        presc <= 32'd0;
        if (times != TIMES_MAX) begin
          times <= times + 15'd1;
        end
      end else begin
        presc <= presc + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_type_buffer.sv
// tb/tb_type_buffer.sv - self-checking bench for type_buffer with a slot-array reference model
module tb_type_buffer;

  localparam int CLK_HZ = 100;
  localparam int M_IDLE = 0, M_READY = 1, M_TYPING = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   tgt_len = 5'd0;
  logic [124:0] target = '0;
  logic         key_valid = 1'b0;
  logic [4:0]   key_code = 5'd0;
  logic         key_bksp = 1'b0;
  logic [124:0] type_data;
  logic [4:0]   tot;
  logic [24:0]  correct;
  logic [14:0]  times;
  logic [9:0]   err_cnt;
  logic         done;

  type_buffer #(.CLK_HZ(CLK_HZ), .SLOTS(25)) dut (
    .clk(clk), .rst(rst), .start(start), .tgt_len(tgt_len), .target(target),
    .key_valid(key_valid), .key_code(key_code), .key_bksp(key_bksp),
    .type_data(type_data), .tot(tot), .correct(correct), .times(times),
    .err_cnt(err_cnt), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // reference model: slot arrays plus a count of timer-running edges
  int m_type [25];
  bit m_corr [25];
  int m_tot, m_len, m_err, m_run, m_st;

  task automatic chk(input string nm, input logic [124:0] act, input logic [124:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [124:0] pack_type();
    logic [124:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v[5*i +: 5] = 5'(m_type[i]);
    return v;
  endfunction

  function automatic logic [24:0] pack_corr();
    logic [24:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v[i] = m_corr[i];
    return v;
  endfunction

  function automatic int m_times();
    int t;
    t = m_run / (CLK_HZ / 10);
    return (t > 32767) ? 32767 : t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 25; i++) begin
      m_type[i] = 0;
      m_corr[i] = 1'b0;
    end
    m_tot = 0; m_err = 0; m_run = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_len = 25;
    m_st  = M_IDLE;
  endtask

  task automatic model_edge(input logic s, input logic [4:0] len, input logic kv,
                            input logic [4:0] kc, input logic kb);
    int prev;
    bit bk;
    int want;
    prev = m_st;
    bk = 1'b0;
`ifdef BACKSPACE_EN
    bk = kb;
`endif
    if (s) begin
      model_clear();
      m_len = (len == 0 || len > 25) ? 25 : int'(len);
      m_st  = M_READY;
      return;
    end
    if (bk) begin
      if (m_st == M_TYPING && m_tot > 0) begin
        m_tot = m_tot - 1;
        m_type[m_tot] = 0;
        m_corr[m_tot] = 1'b0;
      end
    end else if (kv && kc >= 1 && kc <= 27 && (m_st == M_READY || m_st == M_TYPING)
                 && m_tot < m_len) begin
      want = int'(target[5*m_tot +: 5]);
      m_type[m_tot] = int'(kc);
      m_corr[m_tot] = (int'(kc) == want);
      if (int'(kc) != want && m_err < 1023) m_err = m_err + 1;
      m_tot = m_tot + 1;
      m_st  = (m_tot == m_len) ? M_DONE : M_TYPING;
    end
    if ((prev == M_READY || prev == M_TYPING) && m_st == M_TYPING) m_run = m_run + 1;
  endtask

  task automatic step(input logic s, input logic [4:0] len, input logic kv,
                      input logic [4:0] kc, input logic kb);
    start = s; tgt_len = len; key_valid = kv; key_code = kc; key_bksp = kb;
    @(posedge clk);
    model_edge(s, len, kv, kc, kb);
    #1;
    start = 1'b0; key_valid = 1'b0; key_bksp = 1'b0; key_code = 5'd0;
  endtask

  task automatic key(input logic [4:0] kc);
    step(1'b0, tgt_len, 1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, tgt_len, 1'b0, 5'd0, 1'b0);
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("type", type_data, pack_type());
      chk("tot", 125'(tot), 125'(m_tot));
      chk("correct", 125'(correct), 125'(pack_corr()));
      chk("times", 125'(times), 125'(m_times()));
      chk("err_cnt", 125'(err_cnt), 125'(m_err));
      chk("done", 125'(done), 125'(m_st == M_DONE));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_type", type_data, 125'd0);
    chk("rst_tot", 125'(tot), 125'd0);
    chk("rst_done", 125'(done), 125'd0);
    chk("rst_times", 125'(times), 125'd0);
    chk("rst_err", 125'(err_cnt), 125'd0);
    chk_en = 1'b1;

    // keys in IDLE are ignored
    key(5'd3);
    chk("idle_key", 125'(tot), 125'd0);

    // "cat" typed back to back
    target = '0;
    target[14:0] = 15'd20515;
    step(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    chk("cat_ready_tot", 125'(tot), 125'd0);
    key(5'd3); key(5'd1);
    chk("cat_not_done", 125'(done), 125'd0);
    key(5'd20);
    chk("cat_type", 125'(type_data[14:0]), 125'd20515);
    chk("cat_correct", 125'(correct), 125'd7);
    chk("cat_done", 125'(done), 125'd1);
    chk("cat_err", 125'(err_cnt), 125'd0);
    key(5'd5);
    chk("cat_extra_key", 125'(tot), 125'd3);

    // timed round: 35 cycles from first to last key
    step(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    key(5'd3); idle(17); key(5'd1); idle(16); key(5'd20);
    chk("timed_times", 125'(times), 125'd3);
    idle(20);
    chk("timed_frozen", 125'(times), 125'd3);

    // backspace round
    step(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    key(5'd3); key(5'd9);
    step(1'b0, 5'd3, 1'b0, 5'd0, 1'b1);
`ifdef BACKSPACE_EN
    chk("bk_tot", 125'(tot), 125'd1);
    chk("bk_slot1", 125'(type_data[9:5]), 125'd0);
    chk("bk_corr1", 125'(correct[1]), 125'd0);
`endif
    key(5'd1);
`ifdef BACKSPACE_EN
    chk("bk_final_tot", 125'(tot), 125'd2);
    chk("bk_final_corr", 125'(correct), 125'd3);
    chk("bk_final_err", 125'(err_cnt), 125'd1);
`else
    chk("nobk_tot", 125'(tot), 125'd3);
    chk("nobk_done", 125'(done), 125'd1);
    chk("nobk_corr", 125'(correct), 125'd1);
    chk("nobk_err", 125'(err_cnt), 125'd2);
`endif

    // key and backspace together, then start together with a key
    step(1'b1, 5'd3, 1'b0, 5'd0, 1'b0);
    key(5'd3); key(5'd1);
    step(1'b0, 5'd3, 1'b1, 5'd3, 1'b1);
`ifdef BACKSPACE_EN
    chk("both_tot", 125'(tot), 125'd1);
`else
    chk("both_tot", 125'(tot), 125'd3);
`endif
    step(1'b1, 5'd3, 1'b1, 5'd3, 1'b0);
    chk("start_key_tot", 125'(tot), 125'd0);
    chk("start_key_type", type_data, 125'd0);
    chk("start_key_done", 125'(done), 125'd0);

    // tgt_len=0 clamps to 25; 26 keys, slot 4 typed wrong
    for (int i = 0; i < 25; i++) target[5*i +: 5] = 5'(i + 1);
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 26; i++) key((i == 4) ? 5'd27 : 5'(i + 1));
    chk("full_tot", 125'(tot), 125'd25);
    chk("full_done", 125'(done), 125'd1);
    chk("full_err", 125'(err_cnt), 125'd1);
    chk("full_corr", 125'(correct), 125'h1FFFFEF);

    // invalid codes are dropped without counting an error
    step(1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
    key(5'd0); key(5'd30);
    chk("inval_tot", 125'(tot), 125'd0);
    chk("inval_err", 125'(err_cnt), 125'd0);
    key(5'd27);
    chk("space_tot", 125'(tot), 125'd1);
    chk("space_err", 125'(err_cnt), 125'd1);
    idle(3);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/type_buffer.md
Name: type_buffer

Overview:
- Upstream feeder of the VGA text renderer. Accumulates decoded keystrokes into a 25-slot typed-text array and tracks progress against a target sentence.
- Produces the packed `type` array, per-slot `correct` mask, `tot` count and elapsed `times` that the display consumes.
- Sits between the keyboard decoder and the vga top.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; the timer prescaler wraps every CLK_HZ/10 cycles.
- SLOTS, 25, character slots; fixed at 25 to match the 125-bit display bus.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; clear buffer and arm a new round.
- tgt_len  in  5  target sentence length, sampled on start.
- target  in  125  target chars; slot i at [5i+4:5i].
- key_valid  in  1  one-cycle pulse; key_code is valid.
- key_code  in  5  char code: 1–26 = a–z, 27 = space; other codes are invalid.
- key_bksp  in  1  one-cycle backspace pulse.
- type  out  125  typed chars, slot i at [5i+4:5i]; 0 = empty.
- tot  out  5  number of typed chars, 0–25.
- correct  out  25  bit i = slot i typed and equal to target slot i.
- times  out  15  elapsed tenths of a second, saturating.
- err_cnt  out  10  wrong keystrokes this round, saturating.
- done  out  1  high while in DONE.

Behaviour:
- Reset, clock and timing:
  - Synchronous active-high reset on clk.
  - All outputs are registered; every output updates on the clock edge after the causing input.
  - Reset values: type=0, tot=0, correct=0, times=0, err_cnt=0, done=0, state=IDLE, prescaler=0, len_r=25.
- FSM states: IDLE, READY, TYPING, DONE.
  - IDLE: keys and backspace ignored. start -> READY.
  - READY: timer stopped. First accepted key -> TYPING, and the timer starts counting that same edge.
  - TYPING: keys append; backspace removes. tot reaching len_r -> DONE.
  - DONE: timer frozen, keys and backspace ignored, done=1. start -> READY.
- start (any state):
  - Clears type, correct, tot, times, err_cnt and the prescaler.
  - Latches len_r = tgt_len, clamped: 0 or >25 become 25.
  - Goes to READY. start has priority over key_valid and key_bksp in the same cycle.
- Accepted key:
  - Conditions: key_valid, key_code in 1..27, state READY or TYPING, tot < len_r.
  - Writes slot tot; sets correct[tot] = (key_code == target slot tot); tot increments.
  - A mismatch increments err_cnt, saturating at 1023.
  - Invalid codes are dropped silently; no error is counted.
- Backspace (BACKSPACE_EN only):
  - In TYPING with tot>0: clears slot tot-1 and correct[tot-1]; tot decrements.
  - If tot reaches 0, the state stays TYPING and the timer keeps running.
  - At tot=0, or in READY/IDLE/DONE: no effect.
  - key_bksp and key_valid in the same cycle: backspace wins and the key is dropped.
  - err_cnt is never decremented.
- Timer:
  - Prescaler counts 0..CLK_HZ/10-1 while in TYPING. On wrap, times increments, saturating at 32767.
  - Entering DONE freezes both times and the prescaler.
- Completion: the accept that makes tot == len_r moves the FSM to DONE on the same edge; done is visible the next cycle.
- Slots at index >= len_r stay 0 and their correct bits stay 0.

Optional Feature:
- BACKSPACE_EN:
  - Defined: key_bksp is honoured as described in Behaviour.
  - Undefined: key_bksp is ignored entirely. The port remains and is unused. Typed chars are immutable until the next start.

Test Plan:
- Reset with all inputs 0, then start with tgt_len=3, target="cat" (3,1,20) -> state READY; type=0, tot=0, times=0, done=0.
- Keys 3,1,20 on separate cycles -> type[14:0] = {20,1,3}, tot=3, correct=3'b111, err_cnt=0, done=1 one cycle after the third key; further key 5 ignored.
- CLK_HZ=100 bench, same round, 35 cycles between first and last key -> times=3, frozen afterwards in DONE.
- Start tgt_len=3, keys 3,9, then backspace, then 1 (BACKSPACE_EN defined) -> after backspace tot=1, slot 1 = 0, correct[1]=0; final tot=2, correct=2'b11, err_cnt=1. Without the macro: tot=3, DONE, correct=3'b001.
- key_valid=1 (code 3) and key_bksp=1 in the same cycle at tot=2 -> tot=1, key dropped. start together with key_valid -> buffer cleared, tot=0, READY.
- tgt_len=0 with 26 valid keys -> tot=25, done=1, 26th key ignored. key_code=0 or 30 -> no change, err_cnt unchanged.
